// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response bundle between the control unit and seq_alu
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             flag;

  modport master (
    output start, opcode, operand1, operand2,
    input  ready, busy, done, result, result_hi, flag
  );

  modport slave (
    input  start, opcode, operand1, operand2,
    output ready, busy, done, result, result_hi, flag
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV
module seq_alu #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      reset_n,
  seq_alu_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic                 flag_q, flag_d;

  logic                 ready;
  logic                 accept;
  logic [WIDTH-1:0]     op_a, op_b;
  logic [SHW-1:0]       shamt;
  logic [WIDTH:0]       add_w, sub_w;
  logic [2*WIDTH-1:0]   rol_w, ror_w;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_flag;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_sh, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;

  assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept = bus.start && ready;
  assign op_a   = bus.operand1;
  assign op_b   = bus.operand2;
  assign shamt  = op_b[SHW-1:0];

  assign add_w  = {1'b0, op_a} + {1'b0, op_b};
  assign sub_w  = {1'b0, op_a} - {1'b0, op_b};
  // Rotates: shift a doubled copy so bits leaving one end re-enter at the other.
  assign rol_w  = {op_a, op_a} << shamt;
  assign ror_w  = {op_a, op_a} >> shamt;

  always_comb begin
    alu_res  = '0;
    alu_flag = 1'b0;
    case (bus.opcode)
      4'h0: begin alu_res = add_w[WIDTH-1:0]; alu_flag = add_w[WIDTH]; end
      4'h1: begin alu_res = sub_w[WIDTH-1:0]; alu_flag = sub_w[WIDTH]; end
      4'h4: alu_res = op_a << shamt;
      4'h5: alu_res = op_a >> shamt;
      4'h6: alu_res = rol_w[2*WIDTH-1:WIDTH];
      4'h7: alu_res = ror_w[WIDTH-1:0];
      4'h8: alu_res = op_a & op_b;
      4'h9: alu_res = op_a | op_b;
      4'hA: alu_res = op_a ^ op_b;
      4'hB: alu_res = ~(op_a | op_b);
      4'hC: alu_res = ~(op_a & op_b);
      4'hD: alu_res = ~(op_a ^ op_b);
      4'hE: alu_res = {{(WIDTH-1){1'b0}}, (op_a > op_b)};
      4'hF: alu_res = {{(WIDTH-1){1'b0}}, (op_a == op_b)};
      default: alu_res = '0;
    endcase
  end

  // Shift-add: acc holds {partial high, remaining multiplier bits}; carry of the add drops into the top.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: acc holds {remainder, dividend bits shifting out / quotient bits shifting in}.
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    res_d   = res_q;
    hi_d    = hi_q;
    flag_d  = flag_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (accept) begin
          if (bus.opcode == 4'h2) begin
            state_d = S_MUL;
            acc_d   = {{WIDTH{1'b0}}, op_a};
            opb_d   = op_b;
          end else if (bus.opcode == 4'h3 && op_b != '0) begin
            state_d = S_DIV;
            acc_d   = {{WIDTH{1'b0}}, op_a};
            opb_d   = op_b;
          end else if (bus.opcode == 4'h3) begin
            state_d = S_DONE;
            res_d   = '1;
            hi_d    = op_a;
            flag_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            res_d   = alu_res;
            hi_d    = '0;
            flag_d  = alu_flag;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_d = S_DONE;
          res_d   = mul_next[WIDTH-1:0];
          hi_d    = mul_next[2*WIDTH-1:WIDTH];
          flag_d  = |mul_next[2*WIDTH-1:WIDTH];
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_d = S_DONE;
          res_d   = div_next[WIDTH-1:0];
          hi_d    = div_next[2*WIDTH-1:WIDTH];
          flag_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.ready     = ready;
  assign bus.busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = res_q;
  assign bus.result_hi = hi_q;
  assign bus.flag      = flag_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu against an arithmetic reference model
module tb_seq_alu;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic        flag;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [15:0] last_res = '0;
  logic [15:0] last_hi = '0;
  logic        last_flag = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    longint unsigned A, B, s, m, p;
    A = a; B = b; m = 64'hFFFF; s = B % W;
    e.res = '0; e.hi = '0; e.flag = 1'b0; e.lat = 1; e.acc_cyc = 0;
    case (op)
      4'h0: begin e.res = 16'((A + B) & m); e.flag = (A + B) > m; end
      4'h1: begin e.res = 16'((A - B) & m); e.flag = A < B; end
      4'h2: begin p = A * B; e.res = 16'(p & m); e.hi = 16'(p >> 16); e.flag = (p >> 16) != 0; e.lat = W + 1; end
      4'h3: begin
        if (B == 0) begin e.res = 16'hFFFF; e.hi = a; e.flag = 1'b1; end
        else begin e.res = 16'(A / B); e.hi = 16'(A % B); e.lat = W + 1; end
      end
      4'h4: e.res = 16'((A << s) & m);
      4'h5: e.res = 16'(A >> s);
      4'h6: e.res = 16'(((A << s) | (A >> (W - s))) & m);
      4'h7: e.res = 16'(((A >> s) | (A << (W - s))) & m);
      4'h8: e.res = a & b;
      4'h9: e.res = a | b;
      4'hA: e.res = a ^ b;
      4'hB: e.res = ~(a | b);
      4'hC: e.res = ~(a & b);
      4'hD: e.res = ~(a ^ b);
      4'hE: e.res = (A > B) ? 16'd1 : 16'd0;
      default: e.res = (A == B) ? 16'd1 : 16'd0;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", bus.result, e.res);
          chk("result_hi", bus.result_hi, e.hi);
          chk("flag", bus.flag, e.flag);
          chk("latency", cyc - e.acc_cyc + 1, e.lat);
          last_res = e.res; last_hi = e.hi; last_flag = e.flag;
        end
      end
      if (bus.busy)
        chk("hold_during_busy", {bus.result, bus.result_hi, bus.flag}, {last_res, last_hi, last_flag});
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 200) begin @(negedge clk); guard++; end
    if (!bus.ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    e = model(op, a, b);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    bus.start = 1'b1; bus.opcode = op; bus.operand1 = a; bus.operand2 = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.operand1 = 16'hDEAD; bus.operand2 = 16'hBEEF; bus.opcode = 4'h1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic [3:0]  op;
    logic [15:0] a, b;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.opcode = '0; bus.operand1 = '0; bus.operand2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.result, bus.result_hi, bus.flag, bus.done, bus.busy, bus.ready}, {16'h0, 16'h0, 4'b0001});
    reset_n = 1'b1;

    do_op(4'h0, 16'hFFFF, 16'h0001);
    do_op(4'h1, 16'h0003, 16'h0005);
    do_op(4'h2, 16'h0007, 16'h0009);
    do_op(4'h2, 16'hFFFF, 16'hFFFF);
    do_op(4'h3, 16'd100, 16'd7);
    do_op(4'h3, 16'h1234, 16'h0000);
    do_op(4'h4, 16'h0001, 16'd4);
    do_op(4'h6, 16'h8001, 16'd1);
    do_op(4'h7, 16'h0001, 16'd17);
    do_op(4'h5, 16'h8000, 16'd0);

    do_op(4'h2, 16'h0123, 16'h0456);
    @(negedge clk); @(negedge clk);
    chk("busy_before_ignored_start", bus.busy, 1);
    bus.start = 1'b1; bus.opcode = 4'h0; bus.operand1 = 16'h0001; bus.operand2 = 16'h0001;
    @(posedge clk);
    #1 bus.start = 1'b0;
    do_op(4'h0, 16'h1111, 16'h2222);
    do_op(4'hF, 16'h0042, 16'h0042);

    do_op(4'h3, 16'd1000, 16'd3);
    repeat (8) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_mid_div", {bus.result, bus.result_hi, bus.flag, bus.done, bus.busy, bus.ready}, {16'h0, 16'h0, 4'b0001});
    sb.delete();
    last_res = '0; last_hi = '0; last_flag = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    do_op(4'hF, 16'd5, 16'd5);

    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 3));
      else b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      do_op(op, a, b);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU; the next generation of the datapath ALU. Adds configurable width, a start/done handshake, iterative shift-add multiply and restoring divide with full double-width results, variable shift/rotate amounts, and a status flag. Sits between the accumulator/operand registers and the writeback path of the accumulator CPU. The control unit issues one operation at a time and holds or reloads `acc` on `done`.

## Interface
- `WIDTH`, 16: operand and result width in bits; must be ≥ 4 and a power of two.
- `SHW`, $clog2(WIDTH): derived width of the shift amount; not overridden.

Ports:
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only when `ready`=1.
- `opcode` input 4: operation select, captured on accept.
- `operand1` input WIDTH: A operand, captured on accept.
- `operand2` input WIDTH: B operand or shift amount (low SHW bits), captured on accept.
- `ready` output 1: high in IDLE and DONE; a request may be accepted.
- `busy` output 1: high in MUL or DIV.
- `done` output 1: one-cycle pulse; `result`, `result_hi` and `flag` are valid.
- `result` output WIDTH: primary result.
- `result_hi` output WIDTH: MUL high half, DIV remainder, otherwise 0.
- `flag` output 1: carry, borrow, overflow or divide-by-zero (see Operation).

## Operation
- Accept means `start`=1 and `ready`=1 at a rising edge. Operands and opcode are registered at accept; later input changes have no effect.
- `start` while busy is ignored. There is no queue.
- Opcode map, unsigned, in the same order as the existing ALU:
  - 0 ADD: `flag` = carry out.
  - 1 SUB: `flag` = borrow (A < B).
  - 2 MUL: iterative; result = low half, result_hi = high half; `flag` = (high half ≠ 0).
  - 3 DIV: iterative; result = quotient, result_hi = remainder. If B = 0: no iteration, result = all ones, result_hi = A, `flag`=1.
  - 4 SHL by B[SHW-1:0], zero fill.
  - 5 SHR by B[SHW-1:0], zero fill.
  - 6 ROL by B[SHW-1:0].
  - 7 ROR by B[SHW-1:0].
  - 8 AND; 9 OR; A XOR; B NOR; C NAND; D XNOR.
  - E GT: result = 1 if A > B, else 0.
  - F EQ: result = 1 if A == B, else 0.
  - For opcodes 4–F, `flag`=0 and result_hi=0.
- State machine IDLE / MUL / DIV / DONE:
  - IDLE or DONE, accept, opcode 2 → MUL; opcode 3 with B ≠ 0 → DIV; any other opcode → DONE with results registered.
  - IDLE or DONE, no accept → IDLE.
  - MUL / DIV: counter runs 0..WIDTH-1. One shift-add or restore step per cycle, on internal 2×WIDTH registers. After the step at count WIDTH-1, write the outputs → DONE.
- `done` = (state == DONE). `ready` = (state ∈ {IDLE, DONE}). Accept in DONE gives back-to-back operation.
- `result`, `result_hi` and `flag` hold their values until the next completion. They do not change during MUL/DIV iteration.

## Timing
- Reset (async assert, any state including mid-MUL/DIV): state=IDLE; `result`, `result_hi`, `flag`, `done`, `busy` = 0; `ready`=1; counter=0.
- Deassertion of `reset_n` is synchronised externally.
- Single-cycle ops and DIV-by-zero: accept at edge k; outputs and `done` valid in the cycle after edge k (latency 1).
- MUL and DIV: accept at edge k; `busy` high from edge k to edge k+WIDTH; `done` high for one cycle after edge k+WIDTH (latency WIDTH+1; 17 for WIDTH=16).
- `done` is never high for two consecutive cycles unless a new operation was accepted while in DONE.
- Shift or rotate amount 0 returns A unchanged. Amounts wrap modulo WIDTH (B[SHW-1:0] only).

## Test plan
- ADD 0xFFFF + 0x0001, then SUB 0x0003 − 0x0005 (WIDTH=16) → result 0x0000 with flag=1 one cycle after accept; then 0xFFFE with flag=1.
- MUL 0x0007 × 0x0009 → busy for 16 cycles, then done with result 0x003F, result_hi 0, flag 0. MUL 0xFFFF × 0xFFFF → result 0x0001, result_hi 0xFFFE, flag 1.
- DIV 100 / 7 → result 0x000E, result_hi 0x0002 at latency 17. DIV 0x1234 / 0 → latency 1, result 0xFFFF, result_hi 0x1234, flag 1.
- SHL 0x0001 by 4 → 0x0010. ROL 0x8001 by 1 → 0x0003. ROR 0x0001 by 17 (wraps to 1) → 0x8000.
- Pulse start with ADD while a MUL is busy → ignored; MUL result unchanged. Accept ADD in the DONE cycle → completes next cycle.
- Drive reset_n low at iteration 8 of a DIV → outputs 0 and ready=1 immediately. After release, EQ 5 == 5 → result 1.
